// File: rtl/apb_slave_regs13.sv
// APB3 completer: CTRL/STAT/ID/scratch register file with programmable wait
// states, error responses for bad accesses and a registered level interrupt.
module apb_slave_regs13 #(
  parameter int          PADDR_WIDTH = 32,
  parameter int          PDATA_WIDTH = 32,
  parameter int          NUM_SCRATCH = 4,
  parameter logic [31:0] ID_VALUE    = 32'hA9B0_0013
) (
  input  logic                   pclock13,
  input  logic                   preset13,
  input  logic                   psel13,
  input  logic                   penable13,
  input  logic                   prwd13,
  input  logic [PADDR_WIDTH-1:0] paddr13,
  input  logic [PDATA_WIDTH-1:0] pwdata13,
  output logic [PDATA_WIDTH-1:0] prdata13,
  output logic                   pready13,
  output logic                   pslverr13,
  output logic                   int13
);

  localparam logic [7:0] OFF_CTRL = 8'h00;
  localparam logic [7:0] OFF_STAT = 8'h04;
  localparam logic [7:0] OFF_ID   = 8'h08;
  localparam logic [7:0] OFF_SCR0 = 8'h0C;
  localparam logic [7:0] OFF_LAST = 8'(12 + 4 * (NUM_SCRATCH - 1));

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  state_t                 state_reg, state_next;
  logic [3:0]             cnt_reg, cnt_next;
  logic [PADDR_WIDTH-1:0] addr_reg;
  logic                   rwd_reg;
  logic [PDATA_WIDTH-1:0] wdata_reg;
  logic [PDATA_WIDTH-1:0] prdata_reg, prdata_next;
  logic                   pready_reg, pready_next;
  logic                   pslverr_reg, pslverr_next;
  logic                   int_reg;
  logic [3:0]             wait_reg;
  logic                   ie_reg;
  logic                   pend_reg;
  logic                   proto_reg;
  logic [PDATA_WIDTH-1:0] scratch_reg [NUM_SCRATCH];

  logic                   setup, active;
  logic                   latch, commit, proto_set;
  logic [PADDR_WIDTH-1:0] sel_addr;
  logic                   sel_rwd;
  logic [7:0]             off;
  logic [7:0]             scr_off;
  logic [5:0]             scr_idx;
  logic                   is_scr;
  logic                   upper_nz;
  logic                   dec_err;
  logic [PDATA_WIDTH-1:0] rd_val;
  logic [PDATA_WIDTH-1:0] rsp_data;
  logic                   ctrl_we, stat_we, pend_set;

  assign setup  = psel13 & ~penable13;
  assign active = psel13 & penable13;

  // Zero-wait transfers respond from the setup edge, so decode the live bus in
  // IDLE and the latched request once in ACCESS.
  assign sel_addr = (state_reg == ST_IDLE) ? paddr13 : addr_reg;
  assign sel_rwd  = (state_reg == ST_IDLE) ? prwd13  : rwd_reg;
  assign off      = sel_addr[7:0];
  assign scr_off  = off - OFF_SCR0;
  assign scr_idx  = scr_off[7:2];
  assign is_scr   = (off >= OFF_SCR0) && (off <= OFF_LAST);

  generate
    if (PADDR_WIDTH > 8) begin : g_upper
      assign upper_nz = |sel_addr[PADDR_WIDTH-1:8];
    end else begin : g_no_upper
      assign upper_nz = 1'b0;
    end
  endgenerate

  assign dec_err = (off[1:0] != 2'b00) | upper_nz | (off > OFF_LAST)
                 | (sel_rwd & (off == OFF_ID));

  always_comb begin
    rd_val = '0;
    case (off)
      OFF_CTRL: begin
        rd_val[3:0] = wait_reg;
        rd_val[4]   = ie_reg;
      end
      OFF_STAT: begin
        rd_val[0] = pend_reg;
        rd_val[1] = proto_reg;
      end
      OFF_ID:   rd_val = PDATA_WIDTH'(ID_VALUE);
      default: begin
        for (int k = 0; k < NUM_SCRATCH; k++) begin
          if (is_scr && (scr_idx == 6'(k))) rd_val = scratch_reg[k];
        end
      end
    endcase
  end

  assign rsp_data = (dec_err || sel_rwd) ? '0 : rd_val;

  // Next-state and response: pready is registered, so it is loaded one edge
  // ahead of the cycle in which the counter reaches zero.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    pready_next  = 1'b0;
    pslverr_next = 1'b0;
    prdata_next  = '0;
    latch        = 1'b0;
    commit       = 1'b0;
    proto_set    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (setup) begin
          latch      = 1'b1;
          state_next = ST_ACCESS;
          cnt_next   = wait_reg;
          if (wait_reg == 4'd0) begin
            pready_next  = 1'b1;
            pslverr_next = dec_err;
            prdata_next  = rsp_data;
          end
        end else if (active) begin
          // penable without a preceding setup; other slaves' accesses are
          // excluded by qualifying with our own psel.
          proto_set = 1'b1;
        end
      end
      ST_ACCESS: begin
        if (!active) begin
          state_next = ST_IDLE;
          proto_set  = 1'b1;
        end else if (cnt_reg == 4'd0) begin
          state_next = ST_IDLE;
          commit     = rwd_reg & ~dec_err;
        end else begin
          cnt_next = cnt_reg - 4'd1;
          if (cnt_reg == 4'd1) begin
            pready_next  = 1'b1;
            pslverr_next = dec_err;
            prdata_next  = rsp_data;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign ctrl_we  = commit & (off == OFF_CTRL);
  assign stat_we  = commit & (off == OFF_STAT);
  assign pend_set = commit & is_scr;

  always_ff @(posedge pclock13 or negedge preset13) begin
    if (!preset13) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      addr_reg    <= '0;
      rwd_reg     <= 1'b0;
      wdata_reg   <= '0;
      prdata_reg  <= '0;
      pready_reg  <= 1'b0;
      pslverr_reg <= 1'b0;
      int_reg     <= 1'b0;
      wait_reg    <= '0;
      ie_reg      <= 1'b0;
      pend_reg    <= 1'b0;
      proto_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      if (latch) begin
        addr_reg  <= paddr13;
        rwd_reg   <= prwd13;
        wdata_reg <= pwdata13;
      end
      prdata_reg  <= prdata_next;
      pready_reg  <= pready_next;
      pslverr_reg <= pslverr_next;
      if (ctrl_we) begin
        wait_reg <= wdata_reg[3:0];
        ie_reg   <= wdata_reg[4];
      end
      // Set beats a simultaneous write-one-to-clear.
      pend_reg  <= pend_set  | (pend_reg  & ~(stat_we & wdata_reg[0]));
      proto_reg <= proto_set | (proto_reg & ~(stat_we & wdata_reg[1]));
      int_reg   <= pend_reg & ie_reg;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_SCRATCH; gi++) begin : g_scratch
      always_ff @(posedge pclock13 or negedge preset13) begin
        if (!preset13) begin
          scratch_reg[gi] <= '0;
        end else if (commit && is_scr && (scr_idx == 6'(gi))) begin
          scratch_reg[gi] <= wdata_reg;
        end
      end
    end
  endgenerate

  assign prdata13  = prdata_reg;
  assign pready13  = pready_reg;
  assign pslverr13 = pslverr_reg;
  assign int13     = int_reg;

endmodule

// File: tb/tb_apb_slave_regs13.sv
// Bench for apb_slave_regs13: directed scenarios plus random APB traffic,
// all checked against an address-level model of the register map.
module tb_apb_slave_regs13;

  localparam int          NS = 4;
  localparam logic [31:0] ID = 32'hA9B0_0013;

  logic        pclock13 = 1'b0;
  logic        preset13;
  logic        psel13, penable13, prwd13;
  logic [31:0] paddr13, pwdata13, prdata13;
  logic        pready13, pslverr13, int13;

  always #5 pclock13 = ~pclock13;

  apb_slave_regs13 #(
    .PADDR_WIDTH(32), .PDATA_WIDTH(32), .NUM_SCRATCH(NS), .ID_VALUE(ID)
  ) dut (
    .pclock13 (pclock13),
    .preset13 (preset13),
    .psel13   (psel13),
    .penable13(penable13),
    .prwd13   (prwd13),
    .paddr13  (paddr13),
    .pwdata13 (pwdata13),
    .prdata13 (prdata13),
    .pready13 (pready13),
    .pslverr13(pslverr13),
    .int13    (int13)
  );

  int cmp_count = 0;
  int err_count = 0;

  int          m_wait;
  bit          m_ie, m_pend, m_proto;
  logic [31:0] m_scr [NS];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    cmp_count++;
    if (got !== exp) begin
      err_count++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_wait = 0; m_ie = 0; m_pend = 0; m_proto = 0;
    for (int i = 0; i < NS; i++) m_scr[i] = '0;
  endtask

  // One complete APB transfer, checked against the model, then model update.
  task automatic do_xfer(input bit wr, input logic [31:0] addr, input logic [31:0] data);
    logic [7:0]  off;
    bit          exp_err, leak;
    logic [31:0] exp_rd, got_rd;
    logic        got_err;
    int          exp_waits, n, idx;
    off     = addr[7:0];
    idx     = (int'(off) - 12) / 4;
    exp_err = (addr[1:0] != 2'b00) || (addr[31:8] != 24'd0) ||
              (int'(off) > 12 + 4 * (NS - 1)) || (wr && off == 8'h08);
    exp_rd  = '0;
    if (!exp_err && !wr) begin
      if (off == 8'h00)      exp_rd = {27'b0, m_ie, 4'(m_wait)};
      else if (off == 8'h04) exp_rd = {30'b0, m_proto, m_pend};
      else if (off == 8'h08) exp_rd = ID;
      else                   exp_rd = m_scr[idx];
    end
    exp_waits = m_wait;

    @(negedge pclock13);
    check_val("int13_level", {31'b0, int13}, {31'b0, m_pend & m_ie});
    psel13 = 1'b1; penable13 = 1'b0; prwd13 = wr; paddr13 = addr; pwdata13 = data;
    @(negedge pclock13);
    penable13 = 1'b1;
    n = 0; leak = 0;
    while (!pready13 && n < 40) begin
      if (prdata13 !== '0 || pslverr13 !== 1'b0) leak = 1;
      @(negedge pclock13);
      n++;
    end
    got_rd  = prdata13;
    got_err = pslverr13;
    check_val("pready_seen", {31'b0, pready13}, 32'd1);
    check_val("wait_cycles", 32'(n), 32'(exp_waits));
    check_val("quiet_while_waiting", {31'b0, leak}, 32'd0);
    check_val("pslverr", {31'b0, got_err}, {31'b0, exp_err});
    check_val("prdata", got_rd, exp_rd);
    @(negedge pclock13);
    psel13 = 1'b0; penable13 = 1'b0;
    check_val("pready_one_cycle", {31'b0, pready13}, 32'd0);

    if (wr && !exp_err) begin
      if (off == 8'h00) begin
        m_wait = int'(data[3:0]); m_ie = data[4];
      end else if (off == 8'h04) begin
        if (data[0]) m_pend = 0;
        if (data[1]) m_proto = 0;
      end else begin
        m_scr[idx] = data; m_pend = 1;
      end
    end
    $display("xfer %s addr=0x%08h wdata=0x%08h rdata=0x%08h err=%0d waits=%0d",
             wr ? "WR" : "RD", addr, data, got_rd, got_err, n);
  endtask

  initial begin
    logic [31:0] addr, data;
    bit          wr;
    int          r, sel, quiet;

    preset13 = 1'b0; psel13 = 0; penable13 = 0; prwd13 = 0; paddr13 = '0; pwdata13 = '0;
    model_reset();
    repeat (3) @(negedge pclock13);
    check_val("rst_prdata", prdata13, 32'd0);
    check_val("rst_pready", {31'b0, pready13}, 32'd0);
    check_val("rst_pslverr", {31'b0, pslverr13}, 32'd0);
    check_val("rst_int", {31'b0, int13}, 32'd0);
    preset13 = 1'b1;

    // ID read at zero wait, CTRL then scratch write with WAIT=3
    do_xfer(0, 32'h08, 32'h0);
    do_xfer(1, 32'h00, 32'h13);
    do_xfer(1, 32'h0C, 32'hDEADBEEF);
    do_xfer(0, 32'h0C, 32'h0);
    do_xfer(0, 32'h04, 32'h0);
    // W1C of PEND, then a scratch write sets it again
    do_xfer(1, 32'h04, 32'h1);
    do_xfer(0, 32'h04, 32'h0);
    do_xfer(1, 32'h10, 32'h12345678);
    do_xfer(0, 32'h04, 32'h0);
    // error responses leave state untouched
    do_xfer(1, 32'h08, 32'hFFFFFFFF);
    do_xfer(0, 32'h02, 32'h0);
    do_xfer(0, 32'(12 + 4 * NS), 32'h0);
    do_xfer(0, 32'h100, 32'h0);
    do_xfer(1, 32'h0E, 32'h55);
    do_xfer(0, 32'h0C, 32'h0);
    do_xfer(0, 32'h00, 32'h0);

    // penable without setup: ignored, PROTO raised
    do_xfer(1, 32'h04, 32'h3);
    @(negedge pclock13);
    psel13 = 1; penable13 = 1; prwd13 = 1; paddr13 = 32'h14; pwdata13 = 32'hAAAA5555;
    quiet = 1;
    repeat (3) begin
      @(negedge pclock13);
      psel13 = 0; penable13 = 0;
      if (pready13 !== 1'b0) quiet = 0;
    end
    check_val("no_ready_without_setup", 32'(quiet), 32'd1);
    m_proto = 1;
    do_xfer(0, 32'h04, 32'h0);
    do_xfer(0, 32'h14, 32'h0);

    // psel dropped mid-wait with WAIT=5 aborts the write
    do_xfer(1, 32'h04, 32'h2);
    do_xfer(1, 32'h00, 32'h05);
    @(negedge pclock13);
    psel13 = 1; penable13 = 0; prwd13 = 1; paddr13 = 32'h10; pwdata13 = 32'hCAFEF00D;
    @(negedge pclock13);
    penable13 = 1;
    quiet = 1;
    repeat (2) begin
      @(negedge pclock13);
      if (pready13 !== 1'b0) quiet = 0;
    end
    psel13 = 0; penable13 = 0;
    repeat (6) begin
      @(negedge pclock13);
      if (pready13 !== 1'b0) quiet = 0;
    end
    check_val("no_ready_after_abort", 32'(quiet), 32'd1);
    m_proto = 1;
    do_xfer(0, 32'h10, 32'h0);
    do_xfer(0, 32'h04, 32'h0);

    // async reset in the middle of a WAIT=7 write
    do_xfer(1, 32'h00, 32'h17);
    do_xfer(1, 32'h18, 32'h0BADCAFE);
    @(negedge pclock13);
    @(negedge pclock13);
    psel13 = 1; penable13 = 0; prwd13 = 1; paddr13 = 32'h14; pwdata13 = 32'h77778888;
    @(negedge pclock13);
    penable13 = 1;
    repeat (3) @(negedge pclock13);
    check_val("int_before_reset", {31'b0, int13}, 32'd1);
    #2 preset13 = 1'b0;
    #1;
    check_val("async_rst_int", {31'b0, int13}, 32'd0);
    check_val("async_rst_pready", {31'b0, pready13}, 32'd0);
    check_val("async_rst_prdata", prdata13, 32'd0);
    check_val("async_rst_pslverr", {31'b0, pslverr13}, 32'd0);
    @(negedge pclock13);
    psel13 = 0; penable13 = 0;
    @(negedge pclock13);
    preset13 = 1'b1;
    model_reset();
    do_xfer(0, 32'h14, 32'h0);
    do_xfer(0, 32'h00, 32'h0);

    // random traffic
    for (int t = 0; t < 200; t++) begin
      r    = $urandom_range(0, NS + 3);
      addr = 32'(r * 4);
      sel  = $urandom_range(0, 19);
      if (sel == 0)      addr = addr | 32'($urandom_range(1, 3));
      else if (sel == 1) addr = addr | (32'h100 << $urandom_range(0, 23));
      wr   = 1'($urandom_range(0, 1));
      data = $urandom;
      do_xfer(wr, addr, data);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
    $finish;
  end

endmodule
